i2c_xfer_seq: RTL and testbench

Transaction sequencer for the I2C master byte controller (`i2c_master_byte_ctl`). It accepts a whole transfer request (device address, write length, read length, stop flag) and issues the command sequence START / WRITE / RD_ACK / READ / WR_ACK / STOP over the `cmd`/`cmd_ack` handshake. Write bytes are pulled from a TX source and read bytes are pushed to an RX sink. It sits between the register file in `i2c_top_module` and the byte controller, and replaces the inline command state machine.

---
 rtl/i2c_xfer_seq_pkg.sv | 32 +++
 rtl/i2c_xfer_seq_if.sv | 22 ++
 rtl/i2c_xfer_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_xfer_seq_pkg.sv
// rtl/i2c_xfer_seq_pkg.sv - Byte-controller command encodings and sequencer state type
package i2c_xfer_seq_pkg;

  localparam logic [2:0] CMD_IDLE   = 3'd0;
  localparam logic [2:0] CMD_START  = 3'd1;
  localparam logic [2:0] CMD_STOP   = 3'd2;
  localparam logic [2:0] CMD_WRITE  = 3'd3;
  localparam logic [2:0] CMD_READ   = 3'd4;
  localparam logic [2:0] CMD_RD_ACK = 3'd5;
  localparam logic [2:0] CMD_WR_ACK = 3'd6;

  localparam int ERR_NACK = 0;
  localparam int ERR_AL   = 1;

  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_ADDR,
    SEQ_ADDR_ACK,
    SEQ_FETCH,
    SEQ_WRITE,
    SEQ_WACK,
    SEQ_RSTART,
    SEQ_RADDR,
    SEQ_RADDR_ACK,
    SEQ_READ,
    SEQ_RACK,
    SEQ_STOP,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// rtl/i2c_xfer_seq_if.sv - Command handshake between transfer sequencer and byte controller
interface i2c_xfer_seq_if;

  logic [2:0] cmd_o;
  logic       cmd_ack_i;
  logic [7:0] data_o;
  logic [7:0] data_i;
  logic       ack_bit_o;
  logic       i2c_ack_i;
  logic       al_i;

  modport master (
    output cmd_o, data_o, ack_bit_o,
    input  cmd_ack_i, data_i, i2c_ack_i, al_i
  );

  modport slave (
    input  cmd_o, data_o, ack_bit_o,
    output cmd_ack_i, data_i, i2c_ack_i, al_i
  );

endinterface

// File: rtl/i2c_xfer_seq.sv
// rtl/i2c_xfer_seq.sv - I2C transfer sequencer: START/addr/write/repeated-start/read/STOP
module i2c_xfer_seq
  import i2c_xfer_seq_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             sysclk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             req_i,
  input  logic [6:0]       dev_addr_i,
  input  logic [LEN_W-1:0] wr_len_i,
  input  logic [LEN_W-1:0] rd_len_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic             tx_rd_o,
  input  logic [7:0]       tx_data_i,
  output logic             rx_wr_o,
  output logic [7:0]       rx_data_o,
  i2c_xfer_seq_if.master   bc
);

  localparam logic [LEN_W-1:0] W_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] W_ONE = LEN_W'(1);

  seq_state_t       r_state;
  logic [6:0]       r_addr;
  logic [LEN_W-1:0] r_wr_cnt;
  logic [LEN_W-1:0] r_rd_cnt;
  logic             r_stop;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_err;
  logic             r_tx_rd;
  logic             r_rx_wr;
  logic [7:0]       r_rx_data;
  logic [2:0]       r_cmd;
  logic [7:0]       r_data;
  logic             r_ack_bit;

  logic [LEN_W-1:0] w_wr_sat;
  logic [LEN_W-1:0] w_rd_sat;
  seq_state_t       w_end_state;
  logic [2:0]       w_end_cmd;
  seq_state_t       w_wr_next_state;
  logic [2:0]       w_wr_next_cmd;
  logic             w_wr_next_done;

  // Successor of a finished write phase: repeated start if reads remain, else STOP/DONE.
  always_comb begin
    w_wr_sat        = (wr_len_i > W_MAX) ? W_MAX : wr_len_i;
    w_rd_sat        = (rd_len_i > W_MAX) ? W_MAX : rd_len_i;
    w_end_state     = r_stop ? SEQ_STOP : SEQ_DONE;
    w_end_cmd       = r_stop ? CMD_STOP : CMD_IDLE;
    w_wr_next_state = (r_rd_cnt != '0) ? SEQ_RSTART : w_end_state;
    w_wr_next_cmd   = (r_rd_cnt != '0) ? CMD_START  : w_end_cmd;
    w_wr_next_done  = (r_rd_cnt == '0) && !r_stop;
  end

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= SEQ_IDLE;
      r_addr    <= '0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_stop    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= '0;
      r_tx_rd   <= 1'b0;
      r_rx_wr   <= 1'b0;
      r_rx_data <= '0;
      r_cmd     <= CMD_IDLE;
      r_data    <= '0;
      r_ack_bit <= 1'b0;
    end else begin
      r_tx_rd <= 1'b0;
      r_rx_wr <= 1'b0;
      r_done  <= 1'b0;
      if (!enable_i) begin
        r_state   <= SEQ_IDLE;
        r_cmd     <= CMD_IDLE;
        r_busy    <= 1'b0;
        r_ack_bit <= 1'b0;
      end else if (bc.al_i && r_state != SEQ_IDLE && r_state != SEQ_DONE) begin
        // Bus is no longer ours: no STOP, end the transfer right away.
        r_state       <= SEQ_DONE;
        r_cmd         <= CMD_IDLE;
        r_ack_bit     <= 1'b0;
        r_err[ERR_AL] <= 1'b1;
        r_done        <= 1'b1;
      end else begin
        case (r_state)
          SEQ_IDLE: if (req_i) begin
            r_state  <= SEQ_START;
            r_cmd    <= CMD_START;
            r_busy   <= 1'b1;
            r_err    <= '0;
            r_addr   <= dev_addr_i;
            r_wr_cnt <= w_wr_sat;
            r_rd_cnt <= w_rd_sat;
            r_stop   <= stop_i;
          end
          SEQ_START: if (bc.cmd_ack_i) begin
            r_cmd <= CMD_WRITE;
            if (r_wr_cnt == '0 && r_rd_cnt != '0) begin
              r_state <= SEQ_RADDR;
              r_data  <= {r_addr, 1'b1};
            end else begin
              r_state <= SEQ_ADDR;
              r_data  <= {r_addr, 1'b0};
            end
          end
          SEQ_ADDR: if (bc.cmd_ack_i) begin
            r_state <= SEQ_ADDR_ACK;
            r_cmd   <= CMD_RD_ACK;
          end
          SEQ_ADDR_ACK: if (bc.cmd_ack_i) begin
            if (bc.i2c_ack_i) begin
              r_state         <= SEQ_STOP;
              r_cmd           <= CMD_STOP;
              r_err[ERR_NACK] <= 1'b1;
            end else if (r_wr_cnt != '0) begin
              r_state <= SEQ_FETCH;
              r_cmd   <= CMD_IDLE;
              r_tx_rd <= 1'b1;
            end else begin
              r_state <= w_wr_next_state;
              r_cmd   <= w_wr_next_cmd;
              r_done  <= w_wr_next_done;
            end
          end
          SEQ_FETCH: begin
            r_state <= SEQ_WRITE;
            r_cmd   <= CMD_WRITE;
            r_data  <= tx_data_i;
          end
          SEQ_WRITE: if (bc.cmd_ack_i) begin
            r_state <= SEQ_WACK;
            r_cmd   <= CMD_RD_ACK;
          end
          SEQ_WACK: if (bc.cmd_ack_i) begin
            if (bc.i2c_ack_i) begin
              r_state         <= SEQ_STOP;
              r_cmd           <= CMD_STOP;
              r_err[ERR_NACK] <= 1'b1;
            end else begin
              r_wr_cnt <= r_wr_cnt - W_ONE;
              if (r_wr_cnt == W_ONE) begin
                r_state <= w_wr_next_state;
                r_cmd   <= w_wr_next_cmd;
                r_done  <= w_wr_next_done;
              end else begin
                r_state <= SEQ_FETCH;
                r_cmd   <= CMD_IDLE;
                r_tx_rd <= 1'b1;
              end
            end
          end
          SEQ_RSTART: if (bc.cmd_ack_i) begin
            r_state <= SEQ_RADDR;
            r_cmd   <= CMD_WRITE;
            r_data  <= {r_addr, 1'b1};
          end
          SEQ_RADDR: if (bc.cmd_ack_i) begin
            r_state <= SEQ_RADDR_ACK;
            r_cmd   <= CMD_RD_ACK;
          end
          SEQ_RADDR_ACK: if (bc.cmd_ack_i) begin
            if (bc.i2c_ack_i) begin
              r_state         <= SEQ_STOP;
              r_cmd           <= CMD_STOP;
              r_err[ERR_NACK] <= 1'b1;
            end else begin
              r_state <= SEQ_READ;
              r_cmd   <= CMD_READ;
            end
          end
          SEQ_READ: if (bc.cmd_ack_i) begin
            r_state   <= SEQ_RACK;
            r_cmd     <= CMD_WR_ACK;
            r_ack_bit <= (r_rd_cnt == W_ONE);
            r_rx_data <= bc.data_i;
            r_rx_wr   <= 1'b1;
          end
          SEQ_RACK: if (bc.cmd_ack_i) begin
            r_ack_bit <= 1'b0;
            r_rd_cnt  <= r_rd_cnt - W_ONE;
            if (r_rd_cnt == W_ONE) begin
              r_state <= w_end_state;
              r_cmd   <= w_end_cmd;
              r_done  <= !r_stop;
            end else begin
              r_state <= SEQ_READ;
              r_cmd   <= CMD_READ;
            end
          end
          SEQ_STOP: if (bc.cmd_ack_i) begin
            r_state <= SEQ_DONE;
            r_cmd   <= CMD_IDLE;
            r_done  <= 1'b1;
          end
          SEQ_DONE: begin
            r_state <= SEQ_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= SEQ_IDLE;
            r_cmd   <= CMD_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign tx_rd_o      = r_tx_rd;
  assign rx_wr_o      = r_rx_wr;
  assign rx_data_o    = r_rx_data;
  assign bc.cmd_o     = r_cmd;
  assign bc.data_o    = r_data;
  assign bc.ack_bit_o = r_ack_bit;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb/tb_i2c_xfer_seq.sv - Directed vector bench for i2c_xfer_seq with a byte-controller model
`timescale 1ns/1ps
module tb_i2c_xfer_seq;
  import i2c_xfer_seq_pkg::*;

  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             req;
  logic [6:0]       addr;
  logic [LEN_W-1:0] wr_len;
  logic [LEN_W-1:0] rd_len;
  logic             stop;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic             tx_rd;
  logic [7:0]       tx_data;
  logic             rx_wr;
  logic [7:0]       rx_data;

  always #5 clk = ~clk;

  i2c_xfer_seq_if bc_if ();

  i2c_xfer_seq #(.MAX_LEN(16), .LEN_W(LEN_W)) dut (
    .sysclk_i   (clk),
    .reset_n_i  (rst_n),
    .enable_i   (enable),
    .req_i      (req),
    .dev_addr_i (addr),
    .wr_len_i   (wr_len),
    .rd_len_i   (rd_len),
    .stop_i     (stop),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .tx_rd_o    (tx_rd),
    .tx_data_i  (tx_data),
    .rx_wr_o    (rx_wr),
    .rx_data_o  (rx_data),
    .bc         (bc_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // TX source: first-word-fall-through, advances after each fetch strobe.
  int tx_ptr = 0;
  int tx_base = 0;
  function automatic logic [7:0] tx_byte(input int idx);
    case (idx)
      0:       return 8'hA5;
      1:       return 8'h3C;
      default: return 8'h10 + 8'(idx);
    endcase
  endfunction
  assign tx_data = tx_byte(tx_ptr - tx_base);
  always @(posedge clk) if (tx_rd) tx_ptr <= tx_ptr + 1;

  // Byte-controller model: acks every command two cycles after it appears.
  typedef struct {
    logic [2:0] cmd;
    logic [7:0] data;
    logic       ack_bit;
  } log_t;
  log_t cmd_log[$];
  bit   cfg_nack = 1'b0;
  int   xfer_id = 0;

  initial begin
    int bc_wait = 0;
    int bc_id = 0;
    int bc_rdack = 0;
    int bc_rd = 0;
    bc_if.cmd_ack_i = 1'b0;
    bc_if.i2c_ack_i = 1'b0;
    bc_if.data_i    = 8'h00;
    forever begin
      @(negedge clk);
      if (xfer_id != bc_id) begin
        bc_id = xfer_id;
        bc_rdack = 0;
        bc_rd = 0;
      end
      bc_if.cmd_ack_i = 1'b0;
      bc_if.i2c_ack_i = 1'b0;
      if (bc_if.cmd_o != CMD_IDLE) begin
        bc_wait++;
        if (bc_wait >= 2) begin
          bc_wait = 0;
          bc_if.cmd_ack_i = 1'b1;
          cmd_log.push_back('{bc_if.cmd_o, bc_if.data_o, bc_if.ack_bit_o});
          if (bc_if.cmd_o == CMD_RD_ACK) begin
            bc_if.i2c_ack_i = cfg_nack && (bc_rdack == 0);
            bc_rdack++;
          end
          if (bc_if.cmd_o == CMD_READ) begin
            bc_if.data_i = 8'hC0 + 8'(bc_rd);
            bc_rd++;
          end
        end
      end else begin
        bc_wait = 0;
      end
    end
  end

  int         n_rx = 0;
  int         rx_base = 0;
  int         n_done = 0;
  logic [1:0] done_err = 2'b00;

  always @(negedge clk) begin
    if (rx_wr) begin
      check("rx_data", {24'd0, rx_data}, 32'hC0 + 32'(n_rx - rx_base));
      n_rx++;
    end
    if (done) begin
      n_done++;
      done_err = err;
      check("busy_in_done", {31'd0, busy}, 32'd1);
    end
  end

  int done_base = 0;
  int log_base = 0;

  task automatic start_xfer(input logic [6:0] a, input int w, input int r, input logic s, input bit nk);
    @(negedge clk);
    cfg_nack  = nk;
    xfer_id++;
    tx_base   = tx_ptr;
    rx_base   = n_rx;
    done_base = n_done;
    log_base  = cmd_log.size();
    addr   = a;
    wr_len = LEN_W'(w);
    rd_len = LEN_W'(r);
    stop   = s;
    req    = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_cmd", {29'd0, bc_if.cmd_o}, {29'd0, CMD_START});
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_done_seen", tag), {31'd0, done}, 32'd1);
    @(negedge clk);
    check($sformatf("%s_busy_after", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_done_len", tag), {31'd0, done}, 32'd0);
  endtask

  task automatic wait_cmd(input logic [2:0] c, input logic [7:0] d, input bit use_d, input int min_rx);
    int cyc = 0;
    while (!(bc_if.cmd_o == c && (!use_d || bc_if.data_o == d) && (n_rx - rx_base) >= min_rx)
           && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_cmd_reached", {29'd0, bc_if.cmd_o}, {29'd0, c});
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s_done", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s_err", tag), {30'd0, err}, 32'd0);
    check($sformatf("%s_txrd_rxwr", tag), {30'd0, tx_rd, rx_wr}, 32'd0);
    check($sformatf("%s_rx_data", tag), {24'd0, rx_data}, 32'd0);
    check($sformatf("%s_cmd", tag), {29'd0, bc_if.cmd_o}, {29'd0, CMD_IDLE});
    check($sformatf("%s_data", tag), {24'd0, bc_if.data_o}, 32'd0);
    check($sformatf("%s_ack_bit", tag), {31'd0, bc_if.ack_bit_o}, 32'd0);
  endtask

  task automatic check_seq(input string tag, input int base, input logic [10:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      logic [10:0] e;
      e = exp[i];
      if (base + i < cmd_log.size()) begin
        check($sformatf("%s_cmd%0d", tag, i), {29'd0, cmd_log[base+i].cmd}, {29'd0, e[10:8]});
        if (e[10:8] == CMD_WRITE)
          check($sformatf("%s_wdata%0d", tag, i), {24'd0, cmd_log[base+i].data}, {24'd0, e[7:0]});
      end else begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s_missing%0d: log has %0d entries, need %0d", tag, i, cmd_log.size() - base, exp.size());
      end
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    int         wr;
    int         rd;
    logic       stop;
    bit         nack;
    int         exp_ncmd;
    int         exp_tx;
    int         exp_rx;
    logic [1:0] exp_err;
    logic [2:0] exp_last;
  } vec_t;

  vec_t vecs[8];
  int   vbase[8];

  initial begin
    vecs[0] = '{7'h50, 2, 0,  1'b1, 1'b0, 8,  2, 0,  2'b00, CMD_STOP};
    vecs[1] = '{7'h50, 1, 3,  1'b1, 1'b0, 15, 1, 3,  2'b00, CMD_STOP};
    vecs[2] = '{7'h50, 2, 0,  1'b0, 1'b1, 4,  0, 0,  2'b01, CMD_STOP};
    vecs[3] = '{7'h50, 0, 20, 1'b1, 1'b0, 36, 0, 16, 2'b00, CMD_STOP};
    vecs[4] = '{7'h50, 0, 0,  1'b0, 1'b0, 3,  0, 0,  2'b00, CMD_RD_ACK};
    vecs[5] = '{7'h2A, 0, 2,  1'b0, 1'b0, 7,  0, 2,  2'b00, CMD_WR_ACK};
    vecs[6] = '{7'h7F, 3, 0,  1'b1, 1'b0, 10, 3, 0,  2'b00, CMD_STOP};
    vecs[7] = '{7'h2A, 0, 3,  1'b1, 1'b1, 4,  0, 0,  2'b01, CMD_STOP};

    rst_n = 1'b0; enable = 1'b1; req = 1'b0; addr = '0;
    wr_len = '0; rd_len = '0; stop = 1'b0; bc_if.al_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      int nwa;
      int k;
      start_xfer(vecs[v].addr, vecs[v].wr, vecs[v].rd, vecs[v].stop, vecs[v].nack);
      vbase[v] = log_base;
      wait_done($sformatf("v%0d", v));
      check($sformatf("v%0d_ncmd", v), 32'(cmd_log.size() - log_base), 32'(vecs[v].exp_ncmd));
      check($sformatf("v%0d_ntx", v), 32'(tx_ptr - tx_base), 32'(vecs[v].exp_tx));
      check($sformatf("v%0d_nrx", v), 32'(n_rx - rx_base), 32'(vecs[v].exp_rx));
      check($sformatf("v%0d_ndone", v), 32'(n_done - done_base), 32'd1);
      check($sformatf("v%0d_err", v), {30'd0, done_err}, {30'd0, vecs[v].exp_err});
      if (cmd_log.size() > log_base)
        check($sformatf("v%0d_last", v), {29'd0, cmd_log[cmd_log.size()-1].cmd}, {29'd0, vecs[v].exp_last});
      nwa = 0;
      for (int i = log_base; i < cmd_log.size(); i++)
        if (cmd_log[i].cmd == CMD_WR_ACK) nwa++;
      k = 0;
      for (int i = log_base; i < cmd_log.size(); i++)
        if (cmd_log[i].cmd == CMD_WR_ACK) begin
          check($sformatf("v%0d_ackbit%0d", v, k), {31'd0, cmd_log[i].ack_bit}, {31'd0, k == nwa - 1});
          k++;
        end
    end

    check_seq("v0", vbase[0], '{{CMD_START, 8'h00}, {CMD_WRITE, 8'hA0}, {CMD_RD_ACK, 8'h00},
                                {CMD_WRITE, 8'hA5}, {CMD_RD_ACK, 8'h00}, {CMD_WRITE, 8'h3C},
                                {CMD_RD_ACK, 8'h00}, {CMD_STOP, 8'h00}});
    check_seq("v1", vbase[1], '{{CMD_START, 8'h00}, {CMD_WRITE, 8'hA0}, {CMD_RD_ACK, 8'h00},
                                {CMD_WRITE, 8'hA5}, {CMD_RD_ACK, 8'h00}, {CMD_START, 8'h00},
                                {CMD_WRITE, 8'hA1}, {CMD_RD_ACK, 8'h00}, {CMD_READ, 8'h00},
                                {CMD_WR_ACK, 8'h00}, {CMD_READ, 8'h00}, {CMD_WR_ACK, 8'h00},
                                {CMD_READ, 8'h00}, {CMD_WR_ACK, 8'h00}, {CMD_STOP, 8'h00}});

    // Arbitration loss during the second WRITE.
    start_xfer(7'h50, 2, 0, 1'b1, 1'b0);
    wait_cmd(CMD_WRITE, 8'hA5, 1'b1, 0);
    bc_if.al_i = 1'b1;
    @(negedge clk);
    bc_if.al_i = 1'b0;
    check("al_cmd_idle", {29'd0, bc_if.cmd_o}, {29'd0, CMD_IDLE});
    check("al_done_now", {31'd0, done}, 32'd1);
    wait_done("al");
    check("al_err", {30'd0, done_err}, 32'd2);
    begin
      int nstop = 0;
      for (int i = log_base; i < cmd_log.size(); i++)
        if (cmd_log[i].cmd == CMD_STOP) nstop++;
      check("al_no_stop", 32'(nstop), 32'd0);
    end

    // Request while busy is ignored.
    start_xfer(7'h50, 2, 0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    addr = 7'h11; wr_len = '0; req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_done("busyreq");
    check("busyreq_ncmd", 32'(cmd_log.size() - log_base), 32'd8);
    repeat (3) @(negedge clk);
    check("busyreq_idle_busy", {31'd0, busy}, 32'd0);
    check("busyreq_idle_cmd", {29'd0, bc_if.cmd_o}, {29'd0, CMD_IDLE});

    // Enable low aborts without done.
    start_xfer(7'h50, 2, 0, 1'b1, 1'b0);
    wait_cmd(CMD_WRITE, 8'h00, 1'b0, 0);
    enable = 1'b0;
    @(negedge clk);
    check("abort_cmd", {29'd0, bc_if.cmd_o}, {29'd0, CMD_IDLE});
    check("abort_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(n_done - done_base), 32'd0);
    check("abort_stay_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of the read phase.
    start_xfer(7'h50, 0, 4, 1'b1, 1'b0);
    wait_cmd(CMD_READ, 8'h00, 1'b0, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
